// File: rtl/obstacle_feeder.sv
// rtl/obstacle_feeder.sv - obstacle bit stream and shift strobe source for the track shift register
// Shift period shrinks with level; obstacle bits come from an LFSR filtered by a minimum-gap rule.
module obstacle_feeder #(
  parameter int          CLK_DIV_W        = 24,
  parameter int          BASE_PERIOD      = 5_000_000,
  parameter int          PERIOD_STEP      = 250_000,
  parameter int          MIN_PERIOD       = 1_000_000,
  parameter int          SHIFTS_PER_LEVEL = 16,
  parameter int          MIN_GAP          = 2,
  parameter logic [7:0]  LFSR_SEED        = 8'hA5
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Start,
  input  logic       Halt,
  output logic       BitIn,
  output logic       Shift,
  output logic [3:0] Level,
  output logic       Running
);

  localparam int SC_W = (SHIFTS_PER_LEVEL > 1) ? $clog2(SHIFTS_PER_LEVEL) : 1;
  localparam logic [CLK_DIV_W-1:0] BASE_P  = CLK_DIV_W'(BASE_PERIOD);
  localparam logic [CLK_DIV_W-1:0] STEP_P  = CLK_DIV_W'(PERIOD_STEP);
  localparam logic [CLK_DIV_W-1:0] MIN_P   = CLK_DIV_W'(MIN_PERIOD);
  localparam logic [CLK_DIV_W-1:0] ONE_P   = CLK_DIV_W'(1);
  localparam logic [CLK_DIV_W-1:0] TWO_P   = CLK_DIV_W'(2);
  localparam logic [SC_W-1:0]      SC_LAST = SC_W'(SHIFTS_PER_LEVEL - 1);
  localparam logic [2:0]           GAP_MAX = 3'(MIN_GAP);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t               state, state_n;
  logic [7:0]           lfsr, lfsr_n;
  logic [CLK_DIV_W-1:0] cnt, cnt_n, period, period_n;
  logic [SC_W-1:0]      shift_cnt, shift_cnt_n;
  logic [2:0]           gap, gap_n;
  logic                 bit_n, shift_n, running_n;
  logic [3:0]           level_n;
  logic                 lfsr_fb, candidate;

  // Taps 8,6,5,4 of x^8+x^6+x^5+x^4+1, shifting toward the MSB.
  assign lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign candidate = &lfsr[1:0];

  always_comb begin
    state_n     = state;
    lfsr_n      = {lfsr[6:0], lfsr_fb};
    cnt_n       = cnt;
    period_n    = period;
    shift_cnt_n = shift_cnt;
    gap_n       = gap;
    bit_n       = BitIn;
    shift_n     = 1'b0;
    level_n     = Level;

    if (state == RUN) begin
      if (Halt) begin
        state_n = HALTED;
        bit_n   = 1'b0;
      end else begin
        cnt_n = (cnt == period - ONE_P) ? '0 : cnt + ONE_P;
        if (cnt == period - TWO_P) begin
          if (gap < GAP_MAX) begin
            bit_n = 1'b0;
            gap_n = gap + 3'd1;
          end else begin
            bit_n = candidate;
            gap_n = candidate ? 3'd0 : GAP_MAX;
          end
        end
        if (cnt == period - ONE_P) begin
          shift_n = 1'b1;
          if (shift_cnt == SC_LAST) begin
            shift_cnt_n = '0;
            level_n     = (Level == 4'd15) ? Level : Level + 4'd1;
            // period never drops below MIN_P, so period - MIN_P cannot underflow
            period_n    = ((period - MIN_P) < STEP_P) ? MIN_P : period - STEP_P;
          end else begin
            shift_cnt_n = shift_cnt + SC_W'(1);
          end
        end
      end
    end else if (Start) begin
      state_n     = RUN;
      cnt_n       = '0;
      period_n    = BASE_P;
      level_n     = 4'd0;
      shift_cnt_n = '0;
      gap_n       = 3'd0;
      bit_n       = 1'b0;
    end

    running_n = (state_n == RUN);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      lfsr      <= LFSR_SEED;
      cnt       <= '0;
      period    <= BASE_P;
      shift_cnt <= '0;
      gap       <= 3'd0;
      BitIn     <= 1'b0;
      Shift     <= 1'b0;
      Level     <= 4'd0;
      Running   <= 1'b0;
    end else begin
      state     <= state_n;
      lfsr      <= lfsr_n;
      cnt       <= cnt_n;
      period    <= period_n;
      shift_cnt <= shift_cnt_n;
      gap       <= gap_n;
      BitIn     <= bit_n;
      Shift     <= shift_n;
      Level     <= level_n;
      Running   <= running_n;
    end
  end

endmodule

// File: tb/tb_obstacle_feeder.sv
// tb/tb_obstacle_feeder.sv - self-checking bench for obstacle_feeder
// Directed scenarios plus random Start/Halt/Rst traffic against a countdown/bit-history reference model.
module tb_obstacle_feeder;

  localparam int         BASE = 8;
  localparam int         STEP = 2;
  localparam int         MINP = 4;
  localparam int         SPL  = 4;
  localparam int         GAP  = 2;
  localparam logic [7:0] SEED = 8'hA5;

  logic       Clk = 1'b0;
  logic       Rst, Start, Halt;
  logic       BitIn, Shift, Running;
  logic [3:0] Level;

  obstacle_feeder #(
    .CLK_DIV_W(24), .BASE_PERIOD(BASE), .PERIOD_STEP(STEP), .MIN_PERIOD(MINP),
    .SHIFTS_PER_LEVEL(SPL), .MIN_GAP(GAP), .LFSR_SEED(SEED)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Halt(Halt),
    .BitIn(BitIn), .Shift(Shift), .Level(Level), .Running(Running)
  );

  always #5 Clk = ~Clk;

  int n_assert = 0;
  int n_fail   = 0;
  int edge_no  = 0;
  int e0;

  // Reference model: mode 0 idle, 1 run, 2 halted; m_left counts edges to the next shift.
  int m_mode, m_left, m_period, m_level, m_shifts, m_zeros;
  bit m_bit, m_shift;
  bit m_hist[$];

  int shift_at[$];
  int lv[$];
  bit bits[$];
  bit m_bits[$];
  bit first_bits[8];
  int zeros, min_z, ones;
  bit seen_one;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_period(input int lvl);
    int p;
    p = BASE - STEP * lvl;
    return (p < MINP) ? MINP : p;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_bit = 0; m_shift = 0; m_level = 0;
    m_hist.delete();
    for (int i = 7; i >= 0; i--) m_hist.push_back(SEED[i]);
  endtask

  task automatic model_start();
    m_mode = 1; m_period = BASE; m_left = BASE; m_level = 0;
    m_shifts = 0; m_zeros = 0; m_bit = 0; m_shift = 0;
  endtask

  task automatic model_edge(input logic s, input logic h, input logic r);
    bit cand, nb;
    if (r) begin
      model_reset();
      return;
    end
    cand = m_hist[7] & m_hist[6];
    nb   = m_hist[0] ^ m_hist[2] ^ m_hist[3] ^ m_hist[4];
    void'(m_hist.pop_front());
    m_hist.push_back(nb);
    if (m_mode == 1) begin
      m_shift = 0;
      if (h) begin
        m_mode = 2;
        m_bit  = 0;
      end else begin
        m_left--;
        if (m_left == 1) begin
          if (m_zeros >= GAP && cand) begin m_bit = 1; m_zeros = 0; end
          else begin m_bit = 0; m_zeros++; end
        end else if (m_left == 0) begin
          m_shift = 1;
          m_shifts++;
          if (m_shifts == SPL) begin
            m_shifts = 0;
            m_level  = (m_level < 15) ? m_level + 1 : 15;
            m_period = (m_period - STEP < MINP) ? MINP : m_period - STEP;
          end
          m_left = m_period;
        end
      end
    end else if (s) begin
      model_start();
    end
  endtask

  task automatic cyc(input logic s, input logic h, input logic r);
    Start = s; Halt = h; Rst = r;
    @(posedge Clk);
    model_edge(s, h, r);
    edge_no++;
    @(negedge Clk);
    check("shift", Shift, m_shift);
    check("bitin", BitIn, m_bit);
    check("level", Level, m_level);
    check("running", Running, (m_mode == 1));
    if (Shift === 1'b1) begin
      shift_at.push_back(edge_no);
      lv.push_back(Level);
      bits.push_back(BitIn);
    end
    if (m_shift) m_bits.push_back(m_bit);
    Start = 0; Halt = 0; Rst = 0;
  endtask

  task automatic clear_logs();
    shift_at.delete(); lv.delete(); bits.delete(); m_bits.delete();
  endtask

  task automatic run_until(input int nshifts, input int budget);
    int c = 0;
    while (bits.size() < nshifts && c < budget) begin
      cyc(0, 0, 0);
      c++;
    end
    check("shift_timeout", bits.size() >= nshifts, 1);
  endtask

  initial begin
    Start = 0; Halt = 0; Rst = 1;
    model_reset();

    // Reset and idle with Halt pulses
    cyc(0, 0, 1);
    check("reset_shift", Shift, 0);
    check("reset_bitin", BitIn, 0);
    check("reset_level", Level, 0);
    check("reset_running", Running, 0);
    clear_logs();
    for (int i = 0; i < 30; i++) cyc(0, (i % 5) == 2, 0);
    check("idle_shift_count", shift_at.size(), 0);
    check("idle_running", Running, 0);

    // Start, shift latency/spacing, level progression
    cyc(1, 0, 0);
    e0 = edge_no;
    run_until(14, 400);
    if (shift_at.size() >= 14) begin
      check("first_shift_latency", shift_at[0] - e0, BASE);
      for (int k = 2; k <= 14; k++)
        check("shift_spacing", shift_at[k-1] - shift_at[k-2], exp_period((k - 1) / SPL));
      for (int k = 1; k <= 14; k++)
        check("level_at_shift", lv[k-1], k / SPL);
    end
    for (int k = 0; k < 8; k++) first_bits[k] = m_bits[k];

    // Long run: gap rule, density, level saturation
    run_until(300, 2000);
    if (bits.size() >= 2) begin
      check("first_bit0", bits[0], 0);
      check("first_bit1", bits[1], 0);
    end
    zeros = 0; min_z = 1000; ones = 0; seen_one = 0;
    foreach (bits[i]) begin
      if (bits[i]) begin
        if (seen_one && zeros < min_z) min_z = zeros;
        seen_one = 1; ones++; zeros = 0;
      end else begin
        zeros++;
      end
    end
    check("min_zero_run", min_z >= GAP, 1);
    check("ones_seen", ones > 0, 1);
    check("level_saturated", Level, 15);

    // Halt holds level; restart reinitialises
    cyc(0, 1, 0);
    clear_logs();
    for (int i = 0; i < 12; i++) cyc(0, 0, 0);
    check("halt_no_shift", shift_at.size(), 0);
    check("halt_running", Running, 0);
    check("halt_level_held", Level, 15);
    cyc(1, 0, 0);
    check("restart_level", Level, 0);
    check("restart_running", Running, 1);
    for (int i = 1; i < 7; i++) cyc(0, 0, 0);
    cyc(0, 1, 0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 0);
    check("late_halt_no_shift", shift_at.size(), 0);
    check("late_halt_running", Running, 0);
    cyc(1, 0, 0);
    e0 = edge_no;
    clear_logs();
    run_until(1, 40);
    if (shift_at.size() >= 1) check("restart_latency", shift_at[0] - e0, BASE);
    cyc(1, 1, 0);
    check("start_halt_running", Running, 0);

    // Reset mid-run at counter 3, then replay the power-on bit sequence
    cyc(1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0);
    cyc(0, 0, 1);
    check("midrst_shift", Shift, 0);
    check("midrst_bitin", BitIn, 0);
    check("midrst_level", Level, 0);
    check("midrst_running", Running, 0);
    for (int i = 0; i < 30; i++) cyc(0, (i % 5) == 2, 0);
    clear_logs();
    cyc(1, 0, 0);
    run_until(8, 200);
    if (bits.size() >= 8)
      for (int k = 0; k < 8; k++) check("replay_bit", bits[k], first_bits[k]);

    // Random Start/Halt/Rst traffic
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 149) == 0, $urandom_range(0, 699) == 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
